bus_cycle_ctrl: RTL

//  Parametrised bus-cycle controller for the multiplexed peripheral interface.

---
 rtl/bus_cycle_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bus_cycle_ctrl.sv
// Bus-cycle controller for the multiplexed peripheral interface.
// Latches an ALE/CS qualified address, then runs one read or write strobe
// with a minimum wait period, READY extension and a timeout abort.
module bus_cycle_ctrl #(
    parameter int NUM_CS      = 4,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ale,
    input  logic [NUM_CS-1:0] cs,
    input  logic              rdb,
    input  logic              wrb,
    input  logic [ADDR_W-1:0] ad_in,
    input  logic              ready,
    output logic              load,
    output logic              oeb,
    output logic              wr_rdb,
    output logic [NUM_CS-1:0] sel,
    output logic [ADDR_W-1:0] addr_q,
    output logic              busy,
    output logic              err_timeout
);

    // Counter spans the longest strobe phase (WAIT_CYCLES+TIMEOUT) plus a
    // saturation value one above it.
    localparam int CNT_W = $clog2(WAIT_CYCLES + TIMEOUT + 2);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] STRB_LAST  = CNT_W'(WAIT_CYCLES + TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(WAIT_CYCLES + TIMEOUT + 1);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_START = 5'b00010,
        S_READ  = 5'b00100,
        S_WRITE = 5'b01000,
        S_TRI   = 5'b10000
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              err_q, err_d;
    logic [NUM_CS-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0] addr_d;
    logic [NUM_CS-1:0] cs_low;

    // Lowest asserted chip select wins: bit i passes only if no lower bit is set.
    for (genvar i = 0; i < NUM_CS; i++) begin : g_low
        if (i == 0) begin : g_first
            assign cs_low[i] = cs[i];
        end else begin : g_rest
            assign cs_low[i] = cs[i] & ~(|cs[i-1:0]);
        end
    end

    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, counter and latch control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        sel_d   = sel_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (ale && |cs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    sel_d   = cs_low;
                    addr_d  = ad_in;
                end
            end
            S_START: begin
                if (!wrb) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end else if (!rdb) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end else if (cnt_q == START_LAST) begin
                    state_d = S_TRI;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_READ, S_WRITE: begin
                // READY only counts once the minimum strobe has elapsed.
                if ((cnt_q >= WAIT_LAST) && ready) begin
                    state_d = S_TRI;
                end else if (cnt_q == STRB_LAST) begin
                    state_d = S_TRI;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_TRI: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, abort flag and address/select latches.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
        end
    end

    // Moore output decodes; the one-hot state keeps the strobes exclusive.
    always_comb begin
        load        = (state_q == S_START);
        oeb         = (state_q == S_READ);
        wr_rdb      = (state_q == S_WRITE);
        busy        = (state_q != S_IDLE);
        err_timeout = (state_q == S_TRI) && err_q;
        sel         = sel_q;
    end

endmodule
